// File: rtl/text_cmd_engine_pkg.sv
// rtl/text_cmd_engine_pkg.sv - command codes, constants and FSM state type for text_cmd_engine
package text_cmd_engine_pkg;

    localparam logic [3:0] CMD_NOP        = 4'd0;
    localparam logic [3:0] CMD_CLEAR      = 4'd1;
    localparam logic [3:0] CMD_HEX        = 4'd2;
    localparam logic [3:0] CMD_NEWLINE    = 4'd3;
    localparam logic [3:0] CMD_SET_CURSOR = 4'd4;
    localparam logic [3:0] CMD_SET_COLOUR = 4'd5;

    localparam logic [7:0]  BLANK_CHAR   = 8'h20;
    localparam logic [11:0] RESET_COLOUR = 12'hFFF;

    localparam logic [12:0] HEX_DIGITS = 13'd16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_HEX   = 2'd2
    } state_t;

endpackage

// File: rtl/text_cmd_engine_hex_digit_ascii.sv
// rtl/text_cmd_engine_hex_digit_ascii.sv - combinational nibble to upper-case ASCII hex digit
//   nibble : 4-bit value 0..15
//   ascii  : '0'..'9' (0x30-0x39) or 'A'..'F' (0x41-0x46)
module hex_digit_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/text_cmd_engine.sv
// rtl/text_cmd_engine.sv - text-mode command engine writing cells into a character framebuffer
//   clk, rst_n    : clock, asynchronous active-low reset
//   cmd, arg      : command code (1..5 valid) and 64-bit operand, captured when ready=1
//   ready         : high when a command can be accepted
//   write_enable  : one framebuffer cell write per cycle
//   write_addr    : cell address row*COLS+col
//   write_value   : {colour[11:0], 12'h0, ascii[7:0]}
module text_cmd_engine
    import text_cmd_engine_pkg::*;
#(
    parameter int COLS = 160,
    parameter int ROWS = 45
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cmd,
    input  logic [63:0] arg,
    output logic        ready,
    output logic        write_enable,
    output logic [12:0] write_addr,
    output logic [31:0] write_value
);

    localparam logic [7:0]  COL_MAX     = 8'(COLS - 1);
    localparam logic [7:0]  ROW_MAX     = 8'(ROWS - 1);
    localparam logic [12:0] ROW_STRIDE  = 13'(COLS);
    localparam logic [12:0] TOTAL_CELLS = 13'(COLS * ROWS);

    state_t      state;
    logic [7:0]  col;
    logic [7:0]  row;
    logic [12:0] row_base;      // always row*COLS, maintained incrementally
    logic [11:0] colour;
    logic [12:0] count;
    logic [63:0] hex_shift;     // remaining HEX digits, next one in [63:60]

    logic [3:0]  nibble;
    logic [7:0]  ascii;
    logic [7:0]  wrap_row;
    logic [12:0] wrap_base;
    logic [7:0]  adv_col;
    logic [7:0]  adv_row;
    logic [12:0] adv_base;
    logic [7:0]  set_col;
    logic [7:0]  set_row;

    // The first digit is written on the accept edge, before hex_shift is loaded.
    assign nibble = (state == S_IDLE) ? arg[63:60] : hex_shift[63:60];

    hex_digit_ascii u_hex (
        .nibble (nibble),
        .ascii  (ascii)
    );

    // Row step with wrap to the top of the screen; shared by NEWLINE and cursor advance.
    always_comb begin
        wrap_row  = row + 8'd1;
        wrap_base = row_base + ROW_STRIDE;
        if (row == ROW_MAX) begin
            wrap_row  = 8'd0;
            wrap_base = 13'd0;
        end
    end

    always_comb begin
        adv_col  = col + 8'd1;
        adv_row  = row;
        adv_base = row_base;
        if (col == COL_MAX) begin
            adv_col  = 8'd0;
            adv_row  = wrap_row;
            adv_base = wrap_base;
        end
    end

    always_comb begin
        set_col = (arg[7:0]  > COL_MAX) ? COL_MAX : arg[7:0];
        set_row = (arg[15:8] > ROW_MAX) ? ROW_MAX : arg[15:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ready        <= 1'b1;
            write_enable <= 1'b0;
            write_addr   <= 13'd0;
            write_value  <= 32'd0;
            col          <= 8'd0;
            row          <= 8'd0;
            row_base     <= 13'd0;
            colour       <= RESET_COLOUR;
            count        <= 13'd0;
            hex_shift    <= 64'd0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!ready) begin
                        // Single-cycle commands hold ready low for one cycle only.
                        ready <= 1'b1;
                    end else begin
                        case (cmd)
                            CMD_CLEAR: begin
                                state        <= S_CLEAR;
                                ready        <= 1'b0;
                                write_enable <= 1'b1;
                                write_addr   <= 13'd0;
                                write_value  <= {colour, 12'h000, BLANK_CHAR};
                                count        <= 13'd1;
                            end
                            CMD_HEX: begin
                                state        <= S_HEX;
                                ready        <= 1'b0;
                                write_enable <= 1'b1;
                                write_addr   <= row_base + 13'(col);
                                write_value  <= {colour, 12'h000, ascii};
                                col          <= adv_col;
                                row          <= adv_row;
                                row_base     <= adv_base;
                                hex_shift    <= arg << 4;
                                count        <= 13'd1;
                            end
                            CMD_NEWLINE: begin
                                ready    <= 1'b0;
                                col      <= 8'd0;
                                row      <= wrap_row;
                                row_base <= wrap_base;
                            end
                            CMD_SET_CURSOR: begin
                                ready    <= 1'b0;
                                col      <= set_col;
                                row      <= set_row;
                                // Constant multiply only on this one-off command; the
                                // per-write address path stays base plus column.
                                row_base <= 13'(int'(set_row) * COLS);
                            end
                            CMD_SET_COLOUR: begin
                                ready  <= 1'b0;
                                colour <= arg[11:0];
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    if (count == TOTAL_CELLS) begin
                        state    <= S_IDLE;
                        ready    <= 1'b1;
                        col      <= 8'd0;
                        row      <= 8'd0;
                        row_base <= 13'd0;
                    end else begin
                        write_enable <= 1'b1;
                        write_addr   <= count;
                        write_value  <= {colour, 12'h000, BLANK_CHAR};
                        count        <= count + 13'd1;
                    end
                end
                S_HEX: begin
                    if (count == HEX_DIGITS) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else begin
                        write_enable <= 1'b1;
                        write_addr   <= row_base + 13'(col);
                        write_value  <= {colour, 12'h000, ascii};
                        col          <= adv_col;
                        row          <= adv_row;
                        row_base     <= adv_base;
                        hex_shift    <= hex_shift << 4;
                        count        <= count + 13'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_cmd_engine.sv
// tb/tb_text_cmd_engine.sv - directed self-checking bench for text_cmd_engine
module tb_text_cmd_engine;

    logic        clk;
    logic        rst_n;
    logic [3:0]  cmd;
    logic [63:0] arg;
    logic        ready;
    logic        write_enable;
    logic [12:0] write_addr;
    logic [31:0] write_value;

    int total;
    int bad;
    int busy;
    logic [12:0] wa[$];
    logic [31:0] wv[$];

    text_cmd_engine #(.COLS(160), .ROWS(45)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .arg          (arg),
        .ready        (ready),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_value  (write_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_cmd(input logic [3:0] c, input logic [63:0] a);
        wa.delete();
        wv.delete();
        busy = 0;
        @(negedge clk);
        cmd = c;
        arg = a;
        @(posedge clk);
        #1;
        cmd = 4'd0;
        arg = 64'd0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (write_enable) begin
                wa.push_back(write_addr);
                wv.push_back(write_value);
            end
            if (ready) break;
            busy++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cmd = 4'd0;
        arg = 64'd0;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", write_enable); end
        total++; if (write_addr !== 13'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", write_addr); end
        total++; if (write_value !== 32'd0) begin bad++; $display("FAIL reset_value got=%h want=0", write_value); end
        // Release and present a command at once; it must be taken on the first edge.
        rst_n = 1'b1;
        cmd = 4'd4;
        arg = 64'h0105;
        @(posedge clk);
        #1;
        cmd = 4'd0;
        arg = 64'd0;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL first_accept got=%b want=0", ready); end
        @(negedge clk);
        run_cmd(4'd2, 64'd0);
        total++; if (wa.size() < 1 || wa[0] !== 13'd165) begin bad++; $display("FAIL first_accept_addr got=%0d want=165", (wa.size() > 0) ? wa[0] : 13'h1FFF); end
    endtask

    task automatic test_clear;
        int addr_err;
        int val_err;
        run_cmd(4'd1, 64'd0);
        total++; if (busy != 7200) begin bad++; $display("FAIL clear_busy got=%0d want=7200", busy); end
        total++; if (wa.size() != 7200) begin bad++; $display("FAIL clear_count got=%0d want=7200", wa.size()); end
        addr_err = 0;
        val_err = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] !== 13'(i)) addr_err++;
            if (wv[i] !== 32'hFFF00020) val_err++;
        end
        total++; if (addr_err != 0) begin bad++; $display("FAIL clear_addrs got=%0d_wrong want=0_wrong", addr_err); end
        total++; if (val_err != 0) begin bad++; $display("FAIL clear_values got=%0d_wrong want=0_wrong", val_err); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL clear_ready_after got=%b want=1", ready); end
        run_cmd(4'd2, 64'd0);
        total++; if (wa.size() < 1 || wa[0] !== 13'd0) begin bad++; $display("FAIL clear_cursor got=%0d want=0", (wa.size() > 0) ? wa[0] : 13'h1FFF); end
    endtask

    task automatic test_hex_cursor;
        string s;
        int addr_err;
        int char_err;
        s = "0000000000020C0F";
        run_cmd(4'd4, 64'h0203);
        total++; if (busy != 1) begin bad++; $display("FAIL setcur_busy got=%0d want=1", busy); end
        total++; if (wa.size() != 0) begin bad++; $display("FAIL setcur_writes got=%0d want=0", wa.size()); end
        run_cmd(4'd2, 64'h0000_0000_0002_0C0F);
        total++; if (busy != 16) begin bad++; $display("FAIL hex_busy got=%0d want=16", busy); end
        total++; if (wa.size() != 16) begin bad++; $display("FAIL hex_count got=%0d want=16", wa.size()); end
        addr_err = 0;
        char_err = 0;
        for (int i = 0; i < wa.size() && i < 16; i++) begin
            if (wa[i] !== 13'(323 + i)) addr_err++;
            if (wv[i] !== {12'hFFF, 12'h000, 8'(s[i])}) char_err++;
        end
        total++; if (addr_err != 0) begin bad++; $display("FAIL hex_addrs got=%0d_wrong want=0_wrong", addr_err); end
        total++; if (char_err != 0) begin bad++; $display("FAIL hex_chars got=%0d_wrong want=0_wrong", char_err); end
        total++; if (wv.size() < 16 || wv[15][7:0] !== 8'h46) begin bad++; $display("FAIL hex_last_char got=%h want=46", (wv.size() > 15) ? wv[15][7:0] : 8'hXX); end
        total++; if (write_addr !== 13'd338) begin bad++; $display("FAIL hold_addr got=%0d want=338", write_addr); end
        total++; if (write_value !== 32'hFFF00046) begin bad++; $display("FAIL hold_value got=%h want=fff00046", write_value); end
    endtask

    task automatic test_wrap;
        string s;
        int char_err;
        s = "0123456789ABCDEF";
        run_cmd(4'd4, {48'd0, 8'd44, 8'd158});
        run_cmd(4'd2, 64'h0123_4567_89AB_CDEF);
        total++; if (wa.size() != 16) begin bad++; $display("FAIL wrap_count got=%0d want=16", wa.size()); end
        if (wa.size() == 16) begin
            total++; if (wa[0] !== 13'd7198) begin bad++; $display("FAIL wrap_addr0 got=%0d want=7198", wa[0]); end
            total++; if (wa[1] !== 13'd7199) begin bad++; $display("FAIL wrap_addr1 got=%0d want=7199", wa[1]); end
            total++; if (wa[2] !== 13'd0) begin bad++; $display("FAIL wrap_addr2 got=%0d want=0", wa[2]); end
            total++; if (wa[15] !== 13'd13) begin bad++; $display("FAIL wrap_addr15 got=%0d want=13", wa[15]); end
            char_err = 0;
            for (int i = 0; i < 16; i++) begin
                if (wv[i][7:0] !== 8'(s[i])) char_err++;
            end
            total++; if (char_err != 0) begin bad++; $display("FAIL wrap_chars got=%0d_wrong want=0_wrong", char_err); end
        end
    endtask

    task automatic test_colour;
        int col_err;
        run_cmd(4'd5, 64'h0F0);
        total++; if (busy != 1) begin bad++; $display("FAIL colour_busy got=%0d want=1", busy); end
        run_cmd(4'd2, 64'hA5A5_A5A5_A5A5_A5A5);
        total++; if (wv.size() != 16) begin bad++; $display("FAIL colour_count got=%0d want=16", wv.size()); end
        col_err = 0;
        for (int i = 0; i < wv.size(); i++) begin
            if (wv[i][31:20] !== 12'h0F0 || wv[i][19:8] !== 12'h000) col_err++;
        end
        total++; if (col_err != 0) begin bad++; $display("FAIL colour_field got=%0d_wrong want=0_wrong", col_err); end
    endtask

    task automatic test_clamp_newline;
        run_cmd(4'd4, 64'hFFFF);
        run_cmd(4'd2, 64'd0);
        total++; if (wa.size() < 2 || wa[0] !== 13'd7199 || wa[1] !== 13'd0) begin bad++; $display("FAIL clamp_addr got=%0d want=7199", (wa.size() > 0) ? wa[0] : 13'h1FFF); end
        run_cmd(4'd4, 64'hFFFF);
        run_cmd(4'd3, 64'd0);
        total++; if (busy != 1 || wa.size() != 0) begin bad++; $display("FAIL newline_busy got=%0d/%0d want=1/0", busy, wa.size()); end
        run_cmd(4'd2, 64'd0);
        total++; if (wa.size() < 1 || wa[0] !== 13'd0) begin bad++; $display("FAIL newline_wrap got=%0d want=0", (wa.size() > 0) ? wa[0] : 13'h1FFF); end
        run_cmd(4'd3, 64'd0);
        run_cmd(4'd2, 64'd0);
        total++; if (wa.size() < 1 || wa[0] !== 13'd160) begin bad++; $display("FAIL newline_row got=%0d want=160", (wa.size() > 0) ? wa[0] : 13'h1FFF); end
    endtask

    task automatic test_ignored_dropped;
        int waited;
        run_cmd(4'd9, 64'h1234);
        total++; if (busy != 0 || wa.size() != 0) begin bad++; $display("FAIL ignore_code got=%0d/%0d want=0/0", busy, wa.size()); end
        run_cmd(4'd4, 64'h0A00);
        // Start a HEX and hold SET_CURSOR on cmd while busy; it must be dropped.
        @(negedge clk);
        cmd = 4'd2;
        arg = 64'd0;
        @(posedge clk);
        #1;
        cmd = 4'd4;
        arg = 64'd0;
        repeat (3) @(negedge clk);
        cmd = 4'd0;
        waited = 0;
        while (!ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b want=1", ready); end
        run_cmd(4'd2, 64'd0);
        total++; if (wa.size() < 1 || wa[0] !== 13'd1616) begin bad++; $display("FAIL drop_cursor got=%0d want=1616", (wa.size() > 0) ? wa[0] : 13'h1FFF); end
    endtask

    task automatic test_reset_abort;
        bit hit;
        int stray_wr;
        int stray_busy;
        hit = 0;
        @(negedge clk);
        cmd = 4'd1;
        arg = 64'd0;
        @(posedge clk);
        #1;
        cmd = 4'd0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (write_enable && write_addr == 13'd100) begin
                hit = 1;
                rst_n = 1'b0;
                break;
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL abort_reach got=0 want=1"); end
        #1;
        total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL abort_we got=%b want=0", write_enable); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray_wr = 0;
        stray_busy = 0;
        repeat (50) begin
            @(negedge clk);
            if (write_enable) stray_wr++;
            if (!ready) stray_busy++;
        end
        total++; if (stray_wr != 0 || stray_busy != 0) begin bad++; $display("FAIL abort_quiet got=%0d/%0d want=0/0", stray_wr, stray_busy); end
        run_cmd(4'd9, 64'd0);
        total++; if (busy != 0 || wa.size() != 0 || ready !== 1'b1) begin bad++; $display("FAIL abort_ignore got=%0d/%0d want=0/0", busy, wa.size()); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_clear();
        test_hex_cursor();
        test_wrap();
        test_colour();
        test_clamp_newline();
        test_ignored_dropped();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
